// File: rtl/vc_arbiter_dest_pkg.sv
// Shared encodings and default parameters for the VC arbiter / destination router.
package vc_arbiter_dest_pkg;

    localparam int BW_DEF       = 6;
    localparam int DEST_BIT_DEF = 4;
    localparam int WEIGHT_DEF   = 4;
    localparam int CW_DEF       = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        FLIGHT = 1'b1
    } state_t;

    typedef enum logic {
        SRC_VC0 = 1'b0,
        SRC_VC1 = 1'b1
    } src_t;

endpackage

// File: rtl/vc_arbiter_dest_if.sv
// VC FIFO read side, destination FIFO write side and status for vc_arbiter_dest.
interface vc_arbiter_dest_if
    import vc_arbiter_dest_pkg::*;
#(
    parameter int BW = BW_DEF,
    parameter int CW = CW_DEF
);
    logic [BW-1:0] VC0_data_out;
    logic          VC0_empty;
    logic [BW-1:0] VC1_data_out;
    logic          VC1_empty;
    logic          D0_almost_full;
    logic          D1_almost_full;
    logic          VC0_rd;
    logic          VC1_rd;
    logic          D0_push;
    logic [BW-1:0] D0_data_in;
    logic          D1_push;
    logic [BW-1:0] D1_data_in;
    logic [CW-1:0] cnt_vc0;
    logic [CW-1:0] cnt_vc1;
    logic          arb_idle;

    // The arbiter pops the VC FIFOs and pushes the destination FIFOs.
    modport master (
        input  VC0_data_out, VC0_empty, VC1_data_out, VC1_empty,
        input  D0_almost_full, D1_almost_full,
        output VC0_rd, VC1_rd, D0_push, D0_data_in, D1_push, D1_data_in,
        output cnt_vc0, cnt_vc1, arb_idle
    );

    modport slave (
        output VC0_data_out, VC0_empty, VC1_data_out, VC1_empty,
        output D0_almost_full, D1_almost_full,
        input  VC0_rd, VC1_rd, D0_push, D0_data_in, D1_push, D1_data_in,
        input  cnt_vc0, cnt_vc1, arb_idle
    );

endinterface

// File: rtl/vc_arbiter_dest_grant.sv
// VC0-priority grant with a bounded anti-starvation turn for VC1.
module vc_rr_grant
#(
    parameter int WEIGHT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_go,
    input  logic i_vc0_empty,
    input  logic i_vc1_empty,
    output logic o_vc0_rd,
    output logic o_vc1_rd
);

    logic [3:0] r_starve_cnt;
    logic       w_starve;
    logic       w_vc0_rd;
    logic       w_vc1_rd;

    assign w_starve = (r_starve_cnt == 4'(WEIGHT));
    assign w_vc0_rd = i_go && !i_vc0_empty && !(w_starve && !i_vc1_empty);
    assign w_vc1_rd = i_go && !i_vc1_empty && !w_vc0_rd;

    assign o_vc0_rd = w_vc0_rd;
    assign o_vc1_rd = w_vc1_rd;

    // Counts VC0 wins only while VC1 is actually waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (w_vc1_rd || i_vc1_empty) begin
            r_starve_cnt <= 4'd0;
        end else if (w_vc0_rd) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/vc_arbiter_dest.sv
// Pops one VC per cycle and routes the returned word to D0 or D1 by its destination bit.
module vc_arbiter_dest
    import vc_arbiter_dest_pkg::*;
#(
    parameter int BW       = BW_DEF,
    parameter int DEST_BIT = DEST_BIT_DEF,
    parameter int WEIGHT   = WEIGHT_DEF,
    parameter int CW       = CW_DEF
) (
    input logic               clk,
    input logic               reset,
    vc_arbiter_dest_if.master bus
);

    logic          w_go;
    logic          w_vc0_rd;
    logic          w_vc1_rd;
    logic          w_deliver;
    logic [BW-1:0] w_word;

    state_t        r_state_p1;
    src_t          r_pend_src_p1;
    logic [CW-1:0] r_cnt_vc0;
    logic [CW-1:0] r_cnt_vc1;

    // Destination is unknown until the word returns, so both sides need room.
    assign w_go = !reset && !bus.D0_almost_full && !bus.D1_almost_full;

    vc_rr_grant #(
        .WEIGHT (WEIGHT)
    ) u_grant (
        .clk         (clk),
        .reset       (reset),
        .i_go        (w_go),
        .i_vc0_empty (bus.VC0_empty),
        .i_vc1_empty (bus.VC1_empty),
        .o_vc0_rd    (w_vc0_rd),
        .o_vc1_rd    (w_vc1_rd)
    );

    assign bus.VC0_rd = w_vc0_rd;
    assign bus.VC1_rd = w_vc1_rd;

    // Stage p1: the popped word returns from the selected VC FIFO.
    assign w_deliver      = (r_state_p1 == FLIGHT) && !reset;
    assign w_word         = (r_pend_src_p1 == SRC_VC1) ? bus.VC1_data_out : bus.VC0_data_out;
    assign bus.D0_push    = w_deliver && !w_word[DEST_BIT];
    assign bus.D1_push    = w_deliver &&  w_word[DEST_BIT];
    assign bus.D0_data_in = w_deliver ? w_word : '0;
    assign bus.D1_data_in = w_deliver ? w_word : '0;
    assign bus.cnt_vc0    = r_cnt_vc0;
    assign bus.cnt_vc1    = r_cnt_vc1;
    assign bus.arb_idle   = (r_state_p1 == IDLE) && bus.VC0_empty && bus.VC1_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_p1    <= IDLE;
            r_pend_src_p1 <= SRC_VC0;
            r_cnt_vc0     <= '0;
            r_cnt_vc1     <= '0;
        end else begin
            r_state_p1 <= (w_vc0_rd || w_vc1_rd) ? FLIGHT : IDLE;
            if (w_vc1_rd) begin
                r_pend_src_p1 <= SRC_VC1;
            end else if (w_vc0_rd) begin
                r_pend_src_p1 <= SRC_VC0;
            end
            if (r_state_p1 == FLIGHT) begin
                if (r_pend_src_p1 == SRC_VC1) begin
                    r_cnt_vc1 <= r_cnt_vc1 + 1'b1;
                end else begin
                    r_cnt_vc0 <= r_cnt_vc0 + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vc_arbiter_dest.sv
// Randomized bench for vc_arbiter_dest against a queue-based behavioural model.
module tb_vc_arbiter_dest;

    localparam int BW       = 6;
    localparam int DEST_BIT = 4;
    localparam int WEIGHT   = 4;
    localparam int CW       = 8;

    logic clk;
    logic reset;

    vc_arbiter_dest_if #(.BW(BW), .CW(CW)) bus ();

    vc_arbiter_dest #(
        .BW       (BW),
        .DEST_BIT (DEST_BIT),
        .WEIGHT   (WEIGHT),
        .CW       (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];

    bit            m_pend;
    bit            m_pend_src;
    logic [BW-1:0] m_pend_word;
    int            m_streak;
    logic [CW-1:0] m_cnt0;
    logic [CW-1:0] m_cnt1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sync_flags();
        bus.VC0_empty = (q0.size() == 0);
        bus.VC1_empty = (q1.size() == 0);
    endtask

    // One clock: drive at negedge, check mid-cycle, advance model after the edge.
    task automatic cycle(input bit rst, input bit af0, input bit af1);
        bit            go, w0, w1, g0, g1, deliver, dst;
        logic [BW-1:0] word;
        reset = rst;
        bus.D0_almost_full = af0;
        bus.D1_almost_full = af1;
        sync_flags();
        #1;
        w0 = (q0.size() != 0);
        w1 = (q1.size() != 0);
        go = !rst && !af0 && !af1;
        g1 = go && w1 && (!w0 || m_streak == WEIGHT);
        g0 = go && w0 && !g1;
        deliver = m_pend && !rst;
        word = m_pend_word;
        dst = word[DEST_BIT];
        chk_eq("VC0_rd", bus.VC0_rd, g0);
        chk_eq("VC1_rd", bus.VC1_rd, g1);
        chk_eq("D0_push", bus.D0_push, deliver && !dst);
        chk_eq("D1_push", bus.D1_push, deliver && dst);
        chk_eq("D0_data_in", bus.D0_data_in, deliver ? word : '0);
        chk_eq("D1_data_in", bus.D1_data_in, deliver ? word : '0);
        chk_eq("cnt_vc0", bus.cnt_vc0, m_cnt0);
        chk_eq("cnt_vc1", bus.cnt_vc1, m_cnt1);
        chk_eq("arb_idle", bus.arb_idle, !m_pend && !w0 && !w1);
        @(posedge clk);
        #1;
        if (rst) begin
            m_pend   = 1'b0;
            m_streak = 0;
            m_cnt0   = '0;
            m_cnt1   = '0;
        end else begin
            if (m_pend) begin
                if (m_pend_src) m_cnt1 = m_cnt1 + 1'b1;
                else            m_cnt0 = m_cnt0 + 1'b1;
            end
            if (g1 || !w1)  m_streak = 0;
            else if (g0)    m_streak = m_streak + 1;
            m_pend     = g0 || g1;
            m_pend_src = g1;
            if (g0) begin
                m_pend_word = q0.pop_front();
                bus.VC0_data_out = m_pend_word;
            end else if (g1) begin
                m_pend_word = q1.pop_front();
                bus.VC1_data_out = m_pend_word;
            end
        end
        sync_flags();
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_pend) && n < budget) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk_eq(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_pend = 1'b0; m_pend_src = 1'b0; m_pend_word = '0;
        m_streak = 0; m_cnt0 = '0; m_cnt1 = '0;
        reset = 1'b1;
        bus.VC0_data_out = '0;
        bus.VC1_data_out = '0;
        bus.D0_almost_full = 1'b0;
        bus.D1_almost_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(BW'($urandom_range(0, 63)));
            q1.push_back(BW'($urandom_range(0, 63)));
        end
        sync_flags();
        @(posedge clk);
        #1;
        @(negedge clk);

        // Reset held with both VCs non-empty.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        q0.delete();
        q1.delete();

        // VC0 only.
        q0.push_back(6'h05);
        q0.push_back(6'h15);
        q0.push_back(6'h05);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        chk_eq("cnt_vc0_three", bus.cnt_vc0, 32'd3);

        // Priority and starvation with both VCs loaded.
        for (int i = 0; i < 20; i++) begin
            q0.push_back(BW'($urandom_range(0, 63)));
            q1.push_back(BW'($urandom_range(0, 63)));
        end
        for (int i = 0; i < 11; i++) cycle(1'b0, 1'b0, 1'b0);
        chk_eq("cnt_vc0_8_pops", bus.cnt_vc0, 32'd11);
        chk_eq("cnt_vc1_2_pops", bus.cnt_vc1, 32'd2);

        // Backpressure while a word is in flight.
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // Random traffic and backpressure.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) q0.push_back(BW'($urandom_range(0, 63)));
            if ($urandom_range(0, 2) == 0) q1.push_back(BW'($urandom_range(0, 63)));
            cycle(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        drain("drain_random", 200);

        // Reset the cycle after a VC1 pop: word is dropped.
        q1.push_back(6'h3A);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk_eq("cnt_vc1_after_midrst", bus.cnt_vc1, 32'd0);

        // Counter wrap on 257 VC1 words.
        for (int i = 0; i < 257; i++) q1.push_back(BW'($urandom_range(0, 63)));
        drain("drain_wrap", 400);
        cycle(1'b0, 1'b0, 1'b0);
        chk_eq("cnt_vc1_wrap", bus.cnt_vc1, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
